// File: rtl/companion_host_if.sv
// Command, byte-stream and decoded-message signals of the companion UART host.
// master = the host block itself, slave = whatever drives/observes it.
interface companion_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  core_id;
  logic        core_id_valid;
  logic [7:0]  cfg_char;
  logic        cfg_char_valid;
  logic        cfg_done;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        joy_valid;
  logic        err;

  modport master (
    input  cmd_valid, cmd_op, cmd_arg, pl_data, pl_valid, tx_busy, rx_data, rx_valid,
    output cmd_ready, pl_ready, tx_data, tx_start, core_id, core_id_valid,
           cfg_char, cfg_char_valid, cfg_done, joy1, joy2, joy_valid, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_arg, pl_data, pl_valid, tx_busy, rx_data, rx_valid,
    input  cmd_ready, pl_ready, tx_data, tx_start, core_id, core_id_valid,
           cfg_char, cfg_char_valid, cfg_done, joy1, joy2, joy_valid, err
  );
endinterface

// File: rtl/companion_host.sv
// Initiator side of the TangCore companion UART protocol: command serializer plus message parser.
// Define COMPANION_HOST_TIMEOUT_EN to add a response timer to the TX_WAIT state.
//
// state      | meaning
// TX_IDLE    | ready for a command
// TX_OP      | sending the op byte
// TX_ARG     | sending argument / length bytes, idx_q = byte index
// TX_PAYLOAD | forwarding payload bytes (op 5 string, op 7 ROM data)
// TX_WAIT    | op 1/2 sent, waiting for the core's reply
// RX_IDLE    | waiting for a message type byte
// RX_JOY     | collecting 4 joypad bytes
// RX_ID      | next byte is the core ID
// RX_STR     | config string, ends on 0x00
module companion_host #(
  parameter int RESP_TIMEOUT = 2_000_000
) (
  input logic              clk,
  input logic              reset,
  companion_host_if.master bus
);
  typedef enum logic [2:0] {TX_IDLE, TX_OP, TX_ARG, TX_PAYLOAD, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_JOY, RX_ID, RX_STR} rx_state_t;

  tx_state_t   tx_state_q, tx_state_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] arg_q, arg_d;
  logic [23:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        pl_ready_q, pl_ready_d;
  logic        err_q, err_d;
  logic [1:0]  jcnt_q, jcnt_d;
  logic [23:0] shadow_q, shadow_d;
  logic [7:0]  core_id_q, core_id_d;
  logic        core_id_valid_q, core_id_valid_d;
  logic [7:0]  cfg_char_q, cfg_char_d;
  logic        cfg_char_valid_q, cfg_char_valid_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic        joy_valid_q, joy_valid_d;

  logic        can_send;
  logic        resp_done;
  logic        tmo_fire;
  logic [1:0]  last_idx;
  logic [1:0]  sel;
  logic [7:0]  arg_byte;

  assign can_send  = !bus.tx_busy && !tx_start_q;
  assign resp_done = (op_q == 4'd1 && core_id_valid_q) || (op_q == 4'd2 && cfg_done_q);

  // Argument byte order per op; sel is the byte lane of arg_q to send next.
  always_comb begin
    last_idx = 2'd0;
    sel      = 2'd0;
    case (op_q)
      4'd3:    begin last_idx = 2'd3; sel = ~idx_q; end
      4'd4:    begin last_idx = 2'd1; sel = {1'b0, ~idx_q[0]}; end
      4'd7:    begin last_idx = 2'd2; sel = 2'd2 - idx_q; end
      4'd9:    begin last_idx = 2'd3; sel = idx_q; end
      default: ;
    endcase
    arg_byte = arg_q[{sel, 3'b000} +: 8];
    if (op_q == 4'd8) arg_byte = {7'b0, arg_q[0]};
  end

  always_comb begin
    tx_state_d       = tx_state_q;
    rx_state_d       = rx_state_q;
    op_d             = op_q;
    arg_d            = arg_q;
    rem_d            = rem_q;
    idx_d            = idx_q;
    tx_data_d        = tx_data_q;
    tx_start_d       = 1'b0;
    pl_ready_d       = 1'b0;
    err_d            = 1'b0;
    jcnt_d           = jcnt_q;
    shadow_d         = shadow_q;
    core_id_d        = core_id_q;
    core_id_valid_d  = 1'b0;
    cfg_char_d       = cfg_char_q;
    cfg_char_valid_d = 1'b0;
    cfg_done_d       = 1'b0;
    joy1_d           = joy1_q;
    joy2_d           = joy2_q;
    joy_valid_d      = 1'b0;

    case (tx_state_q)
      TX_IDLE: if (bus.cmd_valid) begin
        if (bus.cmd_op == 4'd0 || bus.cmd_op >= 4'd10) begin
          err_d = 1'b1;
        end else begin
          op_d       = bus.cmd_op;
          arg_d      = bus.cmd_arg;
          rem_d      = bus.cmd_arg[23:0];
          idx_d      = 2'd0;
          tx_state_d = TX_OP;
        end
      end
      TX_OP: if (can_send) begin
        tx_start_d = 1'b1;
        tx_data_d  = {4'h0, op_q};
        case (op_q)
          4'd1, 4'd2: tx_state_d = TX_WAIT;
          4'd5:       tx_state_d = TX_PAYLOAD;
          default:    tx_state_d = TX_ARG;
        endcase
      end
      TX_ARG: if (can_send) begin
        tx_start_d = 1'b1;
        tx_data_d  = arg_byte;
        idx_d      = idx_q + 2'd1;
        if (idx_q == last_idx)
          tx_state_d = (op_q == 4'd7 && rem_q != '0) ? TX_PAYLOAD : TX_IDLE;
      end
      TX_PAYLOAD: if (can_send && bus.pl_valid) begin
        tx_start_d = 1'b1;
        pl_ready_d = 1'b1;
        tx_data_d  = bus.pl_data;
        if (op_q == 4'd5) begin
          if (bus.pl_data == 8'h00) tx_state_d = TX_IDLE;
        end else begin
          if (rem_q != '0) rem_d = rem_q - 24'd1;
          if (rem_q <= 24'd1) tx_state_d = TX_IDLE;
        end
      end
      TX_WAIT: if (resp_done || tmo_fire) begin
        tx_state_d = TX_IDLE;
        err_d      = tmo_fire;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (bus.rx_valid) begin
      case (rx_state_q)
        RX_IDLE: begin
          jcnt_d = 2'd0;
          case (bus.rx_data)
            8'h01:   rx_state_d = RX_JOY;
            8'h11:   rx_state_d = RX_ID;
            8'h22:   rx_state_d = RX_STR;
            default: ;
          endcase
        end
        RX_JOY: begin
          jcnt_d = jcnt_q + 2'd1;
          case (jcnt_q)
            2'd0: shadow_d[7:0]   = bus.rx_data;
            2'd1: shadow_d[15:8]  = bus.rx_data;
            2'd2: shadow_d[23:16] = bus.rx_data;
            default: begin
              joy1_d      = shadow_q[15:0];
              joy2_d      = {bus.rx_data, shadow_q[23:16]};
              joy_valid_d = 1'b1;
              rx_state_d  = RX_IDLE;
            end
          endcase
        end
        RX_ID: begin
          core_id_d       = bus.rx_data;
          core_id_valid_d = 1'b1;
          rx_state_d      = RX_IDLE;
        end
        RX_STR: begin
          if (bus.rx_data == 8'h00) begin
            cfg_done_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            cfg_char_d       = bus.rx_data;
            cfg_char_valid_d = 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
    // A timed-out reply may be half parsed; drop it so the next message starts clean.
    if (tmo_fire) rx_state_d = RX_IDLE;
  end

`ifdef COMPANION_HOST_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  assign tmo_fire = (tx_state_q == TX_WAIT) && (tmo_q == '0) && !resp_done && !bus.rx_valid;

  always_comb begin
    tmo_d = tmo_q;
    if ((tx_state_d == TX_WAIT && tx_state_q != TX_WAIT) || bus.rx_valid)
      tmo_d = 32'(RESP_TIMEOUT);
    else if (tx_state_q == TX_WAIT && tmo_q != '0)
      tmo_d = tmo_q - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q       <= TX_IDLE;
      rx_state_q       <= RX_IDLE;
      op_q             <= '0;
      arg_q            <= '0;
      rem_q            <= '0;
      idx_q            <= '0;
      tx_data_q        <= '0;
      tx_start_q       <= 1'b0;
      pl_ready_q       <= 1'b0;
      err_q            <= 1'b0;
      jcnt_q           <= '0;
      shadow_q         <= '0;
      core_id_q        <= '0;
      core_id_valid_q  <= 1'b0;
      cfg_char_q       <= '0;
      cfg_char_valid_q <= 1'b0;
      cfg_done_q       <= 1'b0;
      joy1_q           <= '0;
      joy2_q           <= '0;
      joy_valid_q      <= 1'b0;
    end else begin
      tx_state_q       <= tx_state_d;
      rx_state_q       <= rx_state_d;
      op_q             <= op_d;
      arg_q            <= arg_d;
      rem_q            <= rem_d;
      idx_q            <= idx_d;
      tx_data_q        <= tx_data_d;
      tx_start_q       <= tx_start_d;
      pl_ready_q       <= pl_ready_d;
      err_q            <= err_d;
      jcnt_q           <= jcnt_d;
      shadow_q         <= shadow_d;
      core_id_q        <= core_id_d;
      core_id_valid_q  <= core_id_valid_d;
      cfg_char_q       <= cfg_char_d;
      cfg_char_valid_q <= cfg_char_valid_d;
      cfg_done_q       <= cfg_done_d;
      joy1_q           <= joy1_d;
      joy2_q           <= joy2_d;
      joy_valid_q      <= joy_valid_d;
    end
  end

  assign bus.cmd_ready      = (tx_state_q == TX_IDLE);
  assign bus.pl_ready       = pl_ready_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_start       = tx_start_q;
  assign bus.err            = err_q;
  assign bus.core_id        = core_id_q;
  assign bus.core_id_valid  = core_id_valid_q;
  assign bus.cfg_char       = cfg_char_q;
  assign bus.cfg_char_valid = cfg_char_valid_q;
  assign bus.cfg_done       = cfg_done_q;
  assign bus.joy1           = joy1_q;
  assign bus.joy2           = joy2_q;
  assign bus.joy_valid      = joy_valid_q;
endmodule

// File: tb/tb_companion_host.sv
// Directed plus randomized bench for companion_host: transmitter/payload/receiver models
// around the DUT and a byte-list reference of each command's wire format.
module tb_companion_host;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  companion_host_if bus();
  companion_host #(.RESP_TIMEOUT(100)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_q[$];
  logic [7:0] pl_q[$];
  logic [7:0] chars[$];
  int pl_ready_cnt = 0, joy_cnt = 0, cid_cnt = 0, done_cnt = 0, err_cnt = 0;
  int busy_left = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: busy for a random number of cycles after each strobe.
  always @(negedge clk) begin
    if (bus.tx_start) begin
      tx_q.push_back(bus.tx_data);
      check("start_while_busy", 64'(bus.tx_busy), 64'd0);
      check("start_back_to_back", 64'(prev_start), 64'd0);
      busy_left = $urandom_range(1, 4);
    end else if (busy_left > 0) begin
      busy_left--;
    end
    bus.tx_busy = (busy_left > 0);
    prev_start  = bus.tx_start;
  end

  // Payload source: holds the head byte until the DUT acknowledges it.
  always @(negedge clk) begin
    if (bus.pl_ready) begin
      pl_ready_cnt++;
      if (pl_q.size() > 0) void'(pl_q.pop_front());
    end
    bus.pl_valid = (pl_q.size() > 0) && ($urandom_range(0, 3) != 0);
    bus.pl_data  = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (bus.core_id_valid)  cid_cnt++;
    if (bus.cfg_char_valid) chars.push_back(bus.cfg_char);
    if (bus.cfg_done)       done_cnt++;
    if (bus.joy_valid)      joy_cnt++;
    if (bus.err)            err_cnt++;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] arg);
    int guard = 0;
    while (!bus.cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_timeout", 64'(guard < 2000), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!(bus.cmd_ready && !bus.tx_busy) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("command_timeout", 64'(guard < 5000), 64'd1);
    tick(3);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    tick($urandom_range(0, 3));
  endtask

  // Reference: the wire image of a command is the op byte, its argument bytes, then payload.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] arg, input logic [7:0] pl[$]);
    logic [7:0] e[$];
    int npl = 0;
    e.push_back({4'h0, op});
    case (op)
      4'd3: begin e.push_back(arg[31:24]); e.push_back(arg[23:16]);
                  e.push_back(arg[15:8]);  e.push_back(arg[7:0]); end
      4'd4: begin e.push_back(arg[15:8]); e.push_back(arg[7:0]); end
      4'd6: e.push_back(arg[7:0]);
      4'd8: e.push_back({7'b0, arg[0]});
      4'd9: begin e.push_back(arg[7:0]);   e.push_back(arg[15:8]);
                  e.push_back(arg[23:16]); e.push_back(arg[31:24]); end
      4'd7: begin
        e.push_back(arg[23:16]); e.push_back(arg[15:8]); e.push_back(arg[7:0]);
        for (int i = 0; i < int'(arg[23:0]); i++) e.push_back(pl[i]);
        npl = int'(arg[23:0]);
      end
      4'd5: foreach (pl[i]) begin
        e.push_back(pl[i]);
        npl++;
        if (pl[i] == 8'h00) break;
      end
      default: ;
    endcase
    tx_q = {};
    pl_ready_cnt = 0;
    pl_q = pl;
    issue(op, arg);
    wait_done();
    check("tx_count", 64'(tx_q.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < tx_q.size(); i++) check("tx_byte", 64'(tx_q[i]), 64'(e[i]));
    check("pl_ready_count", 64'(pl_ready_cnt), 64'(npl));
    check("cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    pl_q = {};
  endtask

  function automatic logic [7:0] nonzero_byte();
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] s[$];
    logic [3:0] ops[7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [3:0] bad_ops[3] = '{4'd0, 4'd10, 4'd15};
    logic [15:0] j1, j2;
    logic [7:0] id, g;
    int guard;

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_tx_start", 64'(bus.tx_start), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_joy", {32'd0, bus.joy1, bus.joy2}, 64'd0);
    check("rst_core_id", 64'(bus.core_id), 64'd0);
    check("rst_pl_ready", 64'(bus.pl_ready), 64'd0);

    // Directed wire-format cases.
    pl = {};
    run_cmd(4'd3, 32'h12345678, pl);
    pl = '{8'hAA, 8'hBB, 8'hCC};
    run_cmd(4'd7, 32'h00000003, pl);
    pl = {};
    run_cmd(4'd7, 32'h00000000, pl);
    pl = '{8'h48, 8'h69, 8'h00};
    run_cmd(4'd5, 32'h0, pl);

    // Randomized commands.
    for (int n = 0; n < 14; n++) begin
      logic [3:0] op;
      logic [31:0] arg;
      op  = ops[$urandom_range(0, 6)];
      arg = $urandom;
      pl  = {};
      if (op == 4'd7) begin
        arg[23:0] = 24'($urandom_range(0, 6));
        for (int i = 0; i < int'(arg[23:0]); i++) pl.push_back(8'($urandom));
      end else if (op == 4'd5) begin
        for (int i = 0; i < $urandom_range(0, 5); i++) pl.push_back(nonzero_byte());
        pl.push_back(8'h00);
      end
      run_cmd(op, arg, pl);
    end

    // Illegal ops.
    foreach (bad_ops[k]) begin
      tx_q = {};
      err_cnt = 0;
      issue(bad_ops[k], $urandom);
      check("illegal_err_pulse", 64'(bus.err), 64'd1);
      check("illegal_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      tick(5);
      check("illegal_no_tx", 64'(tx_q.size()), 64'd0);
      check("illegal_err_count", 64'(err_cnt), 64'd1);
    end

    // Op 1 with joypad traffic arriving during the wait.
    tx_q = {}; cid_cnt = 0; joy_cnt = 0;
    issue(4'd1, 32'h0);
    tick(20);
    check("op1_tx_count", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check("op1_tx_byte", 64'(tx_q[0]), 64'h01);
    check("op1_waiting", 64'(bus.cmd_ready), 64'd0);
    send_rx(8'h01); send_rx(8'h34); send_rx(8'h12); send_rx(8'h00); send_rx(8'h08);
    tick(2);
    check("joy1", 64'(bus.joy1), 64'h1234);
    check("joy2", 64'(bus.joy2), 64'h0800);
    check("joy_valid_count", 64'(joy_cnt), 64'd1);
    check("op1_still_waiting", 64'(bus.cmd_ready), 64'd0);
    send_rx(8'h11); send_rx(8'h02);
    tick(3);
    check("core_id", 64'(bus.core_id), 64'h02);
    check("core_id_count", 64'(cid_cnt), 64'd1);
    check("op1_done_ready", 64'(bus.cmd_ready), 64'd1);

    // Op 2 config string.
    tx_q = {}; chars = {}; done_cnt = 0;
    issue(4'd2, 32'h0);
    tick(20);
    check("op2_waiting", 64'(bus.cmd_ready), 64'd0);
    send_rx(8'h22); send_rx(8'h54); send_rx(8'h61); send_rx(8'h00);
    tick(3);
    check("op2_char_count", 64'(chars.size()), 64'd2);
    if (chars.size() == 2) begin
      check("op2_char0", 64'(chars[0]), 64'h54);
      check("op2_char1", 64'(chars[1]), 64'h61);
    end
    check("op2_done_count", 64'(done_cnt), 64'd1);
    check("op2_done_ready", 64'(bus.cmd_ready), 64'd1);

    // Unsolicited traffic: garbage dropped, then random string, ID and joypad.
    chars = {}; done_cnt = 0; joy_cnt = 0; cid_cnt = 0; s = {};
    for (int i = 0; i < 3; i++) begin
      g = 8'($urandom);
      if (g == 8'h01 || g == 8'h11 || g == 8'h22) g = 8'h55;
      send_rx(g);
    end
    for (int i = 0; i < $urandom_range(1, 4); i++) s.push_back(nonzero_byte());
    send_rx(8'h22);
    foreach (s[i]) send_rx(s[i]);
    send_rx(8'h00);
    id = 8'($urandom);
    send_rx(8'h11); send_rx(id);
    j1 = 16'($urandom); j2 = 16'($urandom);
    send_rx(8'h01); send_rx(j1[7:0]); send_rx(j1[15:8]); send_rx(j2[7:0]); send_rx(j2[15:8]);
    tick(3);
    check("uns_char_count", 64'(chars.size()), 64'(s.size()));
    for (int i = 0; i < s.size() && i < chars.size(); i++) check("uns_char", 64'(chars[i]), 64'(s[i]));
    check("uns_done_count", 64'(done_cnt), 64'd1);
    check("uns_core_id", 64'(bus.core_id), 64'(id));
    check("uns_id_count", 64'(cid_cnt), 64'd1);
    check("uns_joy", {32'd0, bus.joy1, bus.joy2}, {32'd0, j1, j2});
    check("uns_joy_count", 64'(joy_cnt), 64'd1);

    // Reset in the middle of a ROM payload.
    tx_q = {};
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    pl_q = pl;
    issue(4'd7, 32'h0000000A);
    guard = 0;
    while (tx_q.size() < 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("rom_progress", 64'(tx_q.size() >= 6), 64'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_tx_start", 64'(bus.tx_start), 64'd0);
    end
    reset = 1'b0;
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_tx_start", 64'(bus.tx_start), 64'd0);
      check("post_reset_pl_ready", 64'(bus.pl_ready), 64'd0);
    end
    check("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    pl_q = {};

`ifdef COMPANION_HOST_TIMEOUT_EN
    err_cnt = 0;
    issue(4'd2, 32'h0);
    guard = 1;
    while (!bus.err && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("timeout_near_100", 64'(guard >= 95 && guard <= 115), 64'd1);
    check("timeout_err", 64'(bus.err), 64'd1);
    check("timeout_cmd_ready", 64'(bus.cmd_ready), 64'd1);
`endif

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/companion_host.md
Name: companion_host

Overview:
- Initiator end of the TangCore companion UART protocol. It sits where the BL616 would sit, for FPGA-hosted control and for loopback benches of the core-side IO system.
- Serializes requests into protocol commands 0x01–0x09 and parses the core's messages: 0x01 joypad, 0x11 core ID, 0x22 config string.
- Byte-level: drives an external async_transmitter (TxD_start/TxD_busy) and consumes an external async_receiver (RxD_data/RxD_data_ready).

Parameters:
- RESP_TIMEOUT, 2_000_000, clk cycles to wait for a 0x11/0x22 response (used only with the optional feature).

Ports:
- clk  in  1  logic clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in TX_IDLE
- cmd_op  in  4  protocol command code, 1..9
- cmd_arg  in  32  command argument (see Behaviour)
- pl_data  in  8  payload byte (op 5 string, op 7 ROM data)
- pl_valid  in  1  payload byte present
- pl_ready  out  1  payload byte consumed this cycle
- tx_data  out  8  byte to transmitter
- tx_start  out  1  one-cycle start strobe
- tx_busy  in  1  transmitter busy
- rx_data  in  8  received byte
- rx_valid  in  1  received-byte strobe
- core_id  out  8  last received core ID
- core_id_valid  out  1  pulse when core_id updates
- cfg_char  out  8  config-string character
- cfg_char_valid  out  1  pulse per non-null character
- cfg_done  out  1  pulse on the string's null terminator
- joy1  out  16  last joypad 1 state
- joy2  out  16  last joypad 2 state
- joy_valid  out  1  pulse when joy1/joy2 update
- err  out  1  pulse: illegal op, or timeout

Behaviour:
- Reset: all outputs 0, both FSMs idle, counters 0. Reset mid-command abandons it immediately with no further tx_start.
- Byte send rule: tx_start is asserted for one cycle only when tx_busy=0 and tx_start was 0 in the previous cycle. tx_data is held from the start strobe until the next strobe.
- Command accept: handshake on cmd_valid & cmd_ready. cmd_op and cmd_arg are latched at accept.
  - op 0 or op ≥10: no bytes sent, err pulses the next cycle, FSM stays idle.
- Bytes sent after the op byte, per op:
  - 1, 2: none.
  - 3: arg[31:24], [23:16], [15:8], [7:0].
  - 4: x=arg[15:8], then y=arg[7:0].
  - 6: arg[7:0].
  - 8: {7'b0, arg[0]}.
  - 9: arg[7:0], [15:8], [23:16], [31:24] (hid1 low/high, then hid2 low/high).
  - 7: len=arg[23:0] sent MSB-first, then exactly len payload bytes. len=0 sends header plus 3 length bytes only.
  - 5: payload bytes forwarded until a 0x00 byte; the 0x00 is forwarded too, then the command ends.
- Payload handshake: pl_ready pulses in the same cycle a payload byte is loaded into tx_data with tx_start. The remaining-length counter is 24 bits and never underflows.
- TX FSM states:
  - TX_IDLE → TX_OP.
  - TX_OP → TX_ARG, TX_PAYLOAD or TX_WAIT.
  - TX_ARG uses a byte counter 0..3.
  - TX_PAYLOAD.
  - TX_WAIT (ops 1 and 2 only).
  - Every other op returns to TX_IDLE after its last strobe.
  - TX_WAIT exits to TX_IDLE on core_id_valid (op 1) or cfg_done (op 2).
- RX parser, independent of the TX FSM:
  - RX_IDLE: 0x01 → RX_JOY (4 bytes in order joy1[7:0], joy1[15:8], joy2[7:0], joy2[15:8]). joy1/joy2 update together with joy_valid after the 4th byte; partial bytes are held in a shadow register.
  - RX_IDLE: 0x11 → RX_ID. Next byte goes to core_id with core_id_valid.
  - RX_IDLE: 0x22 → RX_STR. Each non-zero byte gives cfg_char/cfg_char_valid; 0x00 gives cfg_done and returns to RX_IDLE.
  - Any other byte in RX_IDLE is dropped silently.
  - Unsolicited 0x11/0x22 messages are parsed identically.
- Timing:
  - Output pulses occur 1 cycle after the rx_valid that completes the field.
  - A response completing in the same cycle as a new cmd_valid: TX_WAIT exits first; the new command is accepted no earlier than the next cycle.
  - rx and tx are processed concurrently; joypad traffic during TX_WAIT is decoded normally.

Optional Feature:
- Macro COMPANION_HOST_TIMEOUT_EN.
- Defined:
  - A down-counter loads RESP_TIMEOUT on entry to TX_WAIT and reloads on every rx_valid.
  - On reaching 0: err pulses, TX returns to TX_IDLE, and the RX parser is forced to RX_IDLE.
- Undefined: no counter; TX_WAIT waits indefinitely and err reports illegal ops only.

Test Plan:
- op 3, arg 0x12345678:
  - tx bytes 03 12 34 56 78, each strobe only after tx_busy falls; cmd_ready back high after the last strobe.
- op 7, arg 0x000003, payload AA BB CC:
  - tx 07 00 00 03 AA BB CC, exactly 3 pl_ready pulses.
- op 7, len 0:
  - tx 07 00 00 00, no pl_ready.
- op 1, rx 11 02:
  - core_id=0x02 with core_id_valid, returns idle.
- op 2, rx 22 'T' 'a' 00:
  - cfg_char_valid twice ('T','a'), cfg_done once.
- rx 01 34 12 00 08 during TX_WAIT:
  - joy1=0x1234, joy2=0x0800, one joy_valid, wait continues.
- Reset asserted mid-ROM payload:
  - tx_start stays 0, cmd_ready=1 after reset.
- Timeout build, RESP_TIMEOUT=100, op 2 with no rx:
  - err pulse at cycle ~100, cmd_ready=1.
